// File: rtl/reg_writeback_queue_if.sv
// Handshake and bank-port bundle for reg_writeback_queue.
// Producers (ALU, load path, decode) drive the i_* signals; the queue drives the o_* signals.
interface reg_writeback_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
);
    logic                     i_AluValid;
    logic [ADDR_W-1:0]        i_AluAddr;
    logic [DATA_W-1:0]        i_AluData;
    logic                     o_AluReady;
    logic                     i_MemValid;
    logic [ADDR_W-1:0]        i_MemAddr;
    logic [DATA_W-1:0]        i_MemData;
    logic                     o_MemReady;
    logic                     i_WbStall;
    logic [ADDR_W-1:0]        o_WbAddr;
    logic [DATA_W-1:0]        o_WbData;
    logic                     o_WbEn;
    logic [ADDR_W-1:0]        i_LookupAddr;
    logic                     o_FwdHit;
    logic [DATA_W-1:0]        o_FwdData;
    logic [2**ADDR_W-1:0]     o_Pending;
    logic [$clog2(DEPTH):0]   o_Count;

    modport master (
        output i_AluValid, i_AluAddr, i_AluData,
        output i_MemValid, i_MemAddr, i_MemData,
        output i_WbStall, i_LookupAddr,
        input  o_AluReady, o_MemReady, o_WbAddr, o_WbData, o_WbEn,
        input  o_FwdHit, o_FwdData, o_Pending, o_Count
    );

    modport slave (
        input  i_AluValid, i_AluAddr, i_AluData,
        input  i_MemValid, i_MemAddr, i_MemData,
        input  i_WbStall, i_LookupAddr,
        output o_AluReady, o_MemReady, o_WbAddr, o_WbData, o_WbEn,
        output o_FwdHit, o_FwdData, o_Pending, o_Count
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO between the ALU/load paths and the register bank,
// with a pending-write scoreboard and youngest-entry forwarding lookup.
module reg_writeback_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input logic                 i_CLK,
    input logic                 i_RSTn,
    reg_writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic full, empty, mem_ready, alu_ready, push_mem, push_alu, push, pop;
    logic [NREG-1:0]   pending;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    // The load path has priority; only one result is accepted per cycle.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_ready = i_RSTn & ~full;
    assign alu_ready = mem_ready & ~bus.i_MemValid;
    assign push_mem  = bus.i_MemValid & mem_ready;
    assign push_alu  = bus.i_AluValid & alu_ready;
    assign push      = push_mem | push_alu;
    assign pop       = i_RSTn & ~empty & ~bus.i_WbStall;

    assign bus.o_MemReady = mem_ready;
    assign bus.o_AluReady = alu_ready;
    assign bus.o_WbEn     = pop;
    assign bus.o_WbAddr   = empty ? '0 : addr_q[rd_ptr_q];
    assign bus.o_WbData   = empty ? '0 : data_q[rd_ptr_q];
    assign bus.o_Count    = count_q;
    assign bus.o_Pending  = pending;
    assign bus.o_FwdHit   = fwd_hit;
    assign bus.o_FwdData  = fwd_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push_mem ? bus.i_MemAddr : bus.i_AluAddr;
            data_d[wr_ptr_q]  = push_mem ? bus.i_MemData : bus.i_AluData;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Walk oldest to youngest so the last matching entry is the one forwarded.
    always_comb begin
        pending  = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (valid_q[idx]) begin
                pending[addr_q[idx]] = 1'b1;
                if (addr_q[idx] == bus.i_LookupAddr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[idx];
                end
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry payload is never cleared; the valid bits alone qualify it.
    always_ff @(posedge i_CLK) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed and random checks of reg_writeback_queue against a queue-based model
// that tracks pending results as a plain list of (addr, data) pairs.
module tb_reg_writeback_queue;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk;
    logic rstn;
    int   checkCount;
    int   passCount;
    entry_t mq[$];
    bit   lastMemAcc;
    bit   lastAluAcc;

    reg_writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    reg_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_CLK (clk),
        .i_RSTn(rstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One cycle: drive at negedge, check settled outputs, then advance the model
    // to what the queue must hold after the coming posedge.
    task automatic applyStimulus(input bit aluV, input logic [ADDR_W-1:0] aluA, input logic [DATA_W-1:0] aluD,
                                 input bit memV, input logic [ADDR_W-1:0] memA, input logic [DATA_W-1:0] memD,
                                 input bit stall, input bit rstnIn, input logic [ADDR_W-1:0] look);
        int n;
        bit isFull, expMemRdy, expAluRdy, expWb, expHit;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expData, expFwd;
        logic [2**ADDR_W-1:0] expPend;
        @(negedge clk);
        bus.i_AluValid   = aluV;
        bus.i_AluAddr    = aluA;
        bus.i_AluData    = aluD;
        bus.i_MemValid   = memV;
        bus.i_MemAddr    = memA;
        bus.i_MemData    = memD;
        bus.i_WbStall    = stall;
        bus.i_LookupAddr = look;
        rstn             = rstnIn;
        #1;
        n         = mq.size();
        isFull    = (n == DEPTH);
        expMemRdy = rstnIn && !isFull;
        expAluRdy = expMemRdy && !memV;
        expWb     = rstnIn && (n != 0) && !stall;
        expAddr   = (n != 0) ? mq[0].addr : '0;
        expData   = (n != 0) ? mq[0].data : '0;
        expPend   = '0;
        expHit    = 1'b0;
        expFwd    = '0;
        foreach (mq[i]) expPend[mq[i].addr] = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            if (!expHit && mq[i].addr == look) begin
                expHit = 1'b1;
                expFwd = mq[i].data;
            end
        end
        checkOutput("mem_ready", 32'(bus.o_MemReady), 32'(expMemRdy));
        checkOutput("alu_ready", 32'(bus.o_AluReady), 32'(expAluRdy));
        checkOutput("wb_en",     32'(bus.o_WbEn),     32'(expWb));
        checkOutput("wb_addr",   32'(bus.o_WbAddr),   32'(expAddr));
        checkOutput("wb_data",   32'(bus.o_WbData),   32'(expData));
        checkOutput("count",     32'(bus.o_Count),    32'(n));
        checkOutput("pending",   32'(bus.o_Pending),  32'(expPend));
        checkOutput("fwd_hit",   32'(bus.o_FwdHit),   32'(expHit));
        checkOutput("fwd_data",  32'(bus.o_FwdData),  32'(expFwd));
        lastMemAcc = rstnIn && memV && !isFull;
        lastAluAcc = rstnIn && aluV && !memV && !isFull;
        if (!rstnIn) begin
            mq.delete();
        end else begin
            if (expWb) void'(mq.pop_front());
            if (lastMemAcc) mq.push_back('{memA, memD});
            else if (lastAluAcc) mq.push_back('{aluA, aluD});
        end
    endtask

    task automatic idle(input int cycles, input bit stall);
        for (int i = 0; i < cycles; i++)
            applyStimulus(0, '0, '0, 0, '0, '0, stall, 1, ADDR_W'($urandom));
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        bus.i_AluValid = 0; bus.i_AluAddr = '0; bus.i_AluData = '0;
        bus.i_MemValid = 0; bus.i_MemAddr = '0; bus.i_MemData = '0;
        bus.i_WbStall = 0;  bus.i_LookupAddr = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);

        // Reset values and a single ALU result draining the cycle after acceptance.
        applyStimulus(0, '0, '0, 0, '0, '0, 0, 0, 3'd3);
        applyStimulus(1, 3'd3, 8'h5A, 0, '0, '0, 0, 1, 3'd3);
        checkOutput("t1_accepted", 32'(lastAluAcc), 32'd1);
        idle(2, 0);

        // Fill under stall, hold a fifth result until space frees up.
        for (int i = 0; i < 4; i++)
            applyStimulus(i[0], 3'(i), 8'(8'h30 + i), !i[0], 3'(i + 4), 8'(8'h40 + i), 1, 1, 3'(i));
        applyStimulus(1, 3'd7, 8'h77, 0, '0, '0, 1, 1, 3'd7);
        checkOutput("t2_held", 32'(lastAluAcc), 32'd0);
        for (int i = 0; i < 8 && !lastAluAcc; i++)
            applyStimulus(1, 3'd7, 8'h77, 0, '0, '0, 0, 1, 3'd7);
        checkOutput("t2_fifth_in", 32'(lastAluAcc), 32'd1);
        idle(6, 0);

        // Simultaneous ALU and MEM: MEM first, ALU retried next cycle.
        applyStimulus(1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 1, 3'd1);
        checkOutput("t3_alu_blocked", 32'(lastAluAcc), 32'd0);
        applyStimulus(1, 3'd1, 8'h11, 0, '0, '0, 0, 1, 3'd2);
        idle(3, 0);

        // Forwarding picks the youngest of two writes to the same register.
        applyStimulus(1, 3'd5, 8'h01, 0, '0, '0, 1, 1, 3'd5);
        applyStimulus(1, 3'd5, 8'h02, 0, '0, '0, 1, 1, 3'd5);
        applyStimulus(0, '0, '0, 0, '0, '0, 1, 1, 3'd5);
        applyStimulus(0, '0, '0, 0, '0, '0, 1, 1, 3'd6);
        idle(3, 0);

        // Full with no stall: the push waits one cycle; pointers wrap after six pushes.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, '0, '0, 1, 3'(i), 8'(8'hA0 + i), 1, 1, 3'(i));
        applyStimulus(0, '0, '0, 1, 3'd4, 8'hA4, 0, 1, 3'd4);
        checkOutput("t5_full_block", 32'(lastMemAcc), 32'd0);
        applyStimulus(0, '0, '0, 1, 3'd4, 8'hA4, 0, 1, 3'd4);
        applyStimulus(0, '0, '0, 1, 3'd5, 8'hA5, 0, 1, 3'd0);
        idle(6, 0);

        // Reset with three entries queued discards them.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 3'(i + 2), 8'(8'hC0 + i), 0, '0, '0, 1, 1, 3'(i));
        applyStimulus(0, '0, '0, 0, '0, '0, 0, 0, 3'd2);
        idle(3, 0);

        // Random traffic including stalls and occasional resets.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 1) == 1, ADDR_W'($urandom), DATA_W'($urandom),
                          $urandom_range(0, 2) == 0, ADDR_W'($urandom), DATA_W'($urandom),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 49) != 0, ADDR_W'($urandom));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
